// File: rtl/row_package_feeder.sv
// Streams a row of A/B packages from two memories into the dot-product unit.
// Optional FEEDER_PERF_CNT_EN adds a row_cycles busy-cycle counter output.
module row_package_feeder #(
  parameter int unsigned element_width = 32,
  parameter int unsigned no_of_units   = 64,
  parameter int unsigned addr_width    = 10,
  parameter int unsigned gap_cycles    = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [31:0]                           total,
  input  logic [addr_width-1:0]                 base_a,
  input  logic [addr_width-1:0]                 base_b,
  output logic [addr_width-1:0]                 mem_a_addr,
  output logic [addr_width-1:0]                 mem_b_addr,
  output logic                                  mem_rd_en,
  input  logic [element_width*no_of_units-1:0]  mem_a_data,
  input  logic [element_width*no_of_units-1:0]  mem_b_data,
  output logic [element_width*no_of_units-1:0]  first_row_input,
  output logic [element_width*no_of_units-1:0]  second_row_input,
  output logic                                  outsider_read_now,
  output logic [31:0]                           total_out,
  output logic                                  dot_reset,
  input  logic                                  dot_finish,
  output logic                                  busy,
`ifdef FEEDER_PERF_CNT_EN
  output logic [31:0]                           row_cycles,
`endif
  output logic                                  done
);

  localparam int unsigned PkgW = element_width * no_of_units;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRead,
    StWaitData,
    StIssue,
    StGap,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           total_q, total_d;
  logic [31:0]           npk_q, npk_d;
  logic [31:0]           k_q, k_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [addr_width-1:0] base_a_q, base_a_d;
  logic [addr_width-1:0] base_b_q, base_b_d;
  logic [PkgW-1:0]       first_q, first_d;
  logic [PkgW-1:0]       second_q, second_d;
  logic                  fin_prev_q;
  logic                  done_q, done_d;
  logic                  start_ok;

  // done_q is high in the first IDLE cycle, so a start there is dropped.
  assign start_ok = (state_q == StIdle) && start && !done_q;

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    npk_d    = npk_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    first_d  = first_q;
    second_d = second_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_ok) begin
          total_d  = total;
          npk_d    = total / no_of_units;
          base_a_d = base_a;
          base_b_d = base_b;
          k_d      = '0;
          cnt_d    = '0;
          state_d  = StClear;
        end
      end
      StClear: begin
        if (cnt_q == 32'd1) begin
          cnt_d = '0;
          if (npk_q == 32'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRead;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRead: begin
        state_d = StWaitData;
      end
      StWaitData: begin
        first_d  = mem_a_data;
        second_d = mem_b_data;
        state_d  = StIssue;
      end
      StIssue: begin
        k_d   = k_q + 32'd1;
        cnt_d = '0;
        if (gap_cycles == 0) begin
          state_d = ((k_q + 32'd1) < npk_q) ? StRead : StDrain;
        end else begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == gap_cycles - 1) begin
          cnt_d   = '0;
          state_d = (k_q < npk_q) ? StRead : StDrain;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDrain: begin
        // Only a fresh rising edge counts; a level left over from before is ignored.
        if (dot_finish && !fin_prev_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      npk_q      <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      first_q    <= '0;
      second_q   <= '0;
      fin_prev_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      npk_q      <= npk_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      first_q    <= first_d;
      second_q   <= second_d;
      fin_prev_q <= dot_finish;
      done_q     <= done_d;
    end
  end

  assign mem_a_addr        = base_a_q + k_q[addr_width-1:0];
  assign mem_b_addr        = base_b_q + k_q[addr_width-1:0];
  assign mem_rd_en         = (state_q == StRead);
  assign outsider_read_now = (state_q == StIssue);
  assign busy              = (state_q != StIdle);
  assign dot_reset         = !reset || (state_q == StClear);
  assign done              = done_q;
  assign total_out         = total_q;
  assign first_row_input   = first_q;
  assign second_row_input  = second_q;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] row_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cycles_q <= '0;
    end else if (start_ok) begin
      row_cycles_q <= '0;
    end else if (busy) begin
      row_cycles_q <= row_cycles_q + 32'd1;
    end
  end

  assign row_cycles = row_cycles_q;
`endif

endmodule

// File: tb/tb_row_package_feeder.sv
// Directed bench for row_package_feeder: memory and sticky dot_finish models,
// negedge event monitor, hand-computed expectations.
module tb_row_package_feeder;

  localparam int EW = 32;
  localparam int NU = 64;
  localparam int AW = 10;
  localparam int PW = EW * NU;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   total = '0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] base_b = '0;
  logic [AW-1:0] mem_a_addr, mem_b_addr;
  logic          mem_rd_en;
  logic [PW-1:0] mem_a_data = '0;
  logic [PW-1:0] mem_b_data = '0;
  logic [PW-1:0] first_row_input, second_row_input;
  logic          outsider_read_now;
  logic [31:0]   total_out;
  logic          dot_reset;
  logic          dot_finish;
  logic          busy;
  logic          done;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]   row_cycles;
`endif

  logic fin_sticky = 1'b0;
  logic fin_set = 1'b0;
  logic fin_force = 1'b0;
  assign dot_finish = fin_sticky | fin_force;

  row_package_feeder dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .total            (total),
    .base_a           (base_a),
    .base_b           (base_b),
    .mem_a_addr       (mem_a_addr),
    .mem_b_addr       (mem_b_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_a_data       (mem_a_data),
    .mem_b_data       (mem_b_data),
    .first_row_input  (first_row_input),
    .second_row_input (second_row_input),
    .outsider_read_now(outsider_read_now),
    .total_out        (total_out),
    .dot_reset        (dot_reset),
    .dot_finish       (dot_finish),
    .busy             (busy),
`ifdef FEEDER_PERF_CNT_EN
    .row_cycles       (row_cycles),
`endif
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] elem(logic [3:0] sel, int i, logic [AW-1:0] addr);
    logic [7:0] idx;
    idx = i[7:0];
    return {sel, 4'h0, idx, 6'b0, addr};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int i = 0; i < NU; i++) begin
        mem_a_data[i*EW +: EW] <= elem(4'hA, i, mem_a_addr);
        mem_b_data[i*EW +: EW] <= elem(4'hB, i, mem_b_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (dot_reset) fin_sticky <= 1'b0;
    else if (fin_set) fin_sticky <= 1'b1;
  end

  // Monitor state
  int pulse_cyc[$];
  int a_addrs[$];
  int b_addrs[$];
  logic [31:0] pa_lo[$];
  logic [31:0] pa_hi[$];
  logic [31:0] pb_lo[$];
  int done_cnt, done_cyc, dr_cnt, dr_last, rd_cnt, rise_cyc, busy_cnt;
  logic fin_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (busy) busy_cnt++;
        if (dot_reset) begin dr_cnt++; dr_last = cyc; end
        if (mem_rd_en) begin
          rd_cnt++;
          a_addrs.push_back(int'(mem_a_addr));
          b_addrs.push_back(int'(mem_b_addr));
        end
        if (outsider_read_now) begin
          pulse_cyc.push_back(cyc);
          pa_lo.push_back(first_row_input[31:0]);
          pa_hi.push_back(first_row_input[PW-1 -: 32]);
          pb_lo.push_back(second_row_input[31:0]);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (dot_finish && !fin_prev) rise_cyc = cyc;
        fin_prev = dot_finish;
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int qget(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] dget(logic [31:0] q[$], int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pulse_cyc.delete(); a_addrs.delete(); b_addrs.delete();
    pa_lo.delete(); pa_hi.delete(); pb_lo.delete();
    done_cnt = 0; done_cyc = -1; dr_cnt = 0; dr_last = -1;
    rd_cnt = 0; rise_cyc = -100; busy_cnt = 0;
  endtask

  task automatic start_row(logic [31:0] t, logic [AW-1:0] ba, logic [AW-1:0] bb);
    total = t; base_a = ba; base_b = bb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pulses(string tag, int n);
    int b;
    b = 200;
    while (pulse_cyc.size() < n && b > 0) begin tick(); b--; end
    check(tag, pulse_cyc.size(), n);
  endtask

  task automatic check_pkgs(string tag, int n, logic [AW-1:0] ba, logic [AW-1:0] bb);
    for (int j = 0; j < n; j++) begin
      check({tag, "_a_lo"}, dget(pa_lo, j), elem(4'hA, 0, ba + AW'(j)));
      check({tag, "_a_hi"}, dget(pa_hi, j), elem(4'hA, 63, ba + AW'(j)));
      check({tag, "_b_lo"}, dget(pb_lo, j), elem(4'hB, 0, bb + AW'(j)));
    end
  endtask

  // Raise dot_finish once the row sits in DRAIN; optionally hit start in the done cycle.
  task automatic finish_row(string tag, bit coincide, logic [31:0] exp_total);
    int b;
    repeat (4) tick();
    fin_set = 1'b1;
    tick();
    fin_set = 1'b0;
    b = 20;
    while (!done && b > 0) begin tick(); b--; end
    if (coincide) begin
      total = 32'd7; base_a = 10'd77; start = 1'b1;
    end
    tick();
    start = 1'b0;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc - rise_cyc, 1);
    tick();
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_total_held"}, total_out, exp_total);
`ifdef FEEDER_PERF_CNT_EN
    check({tag, "_row_cycles"}, row_cycles, busy_cnt);
    repeat (3) tick();
    check({tag, "_row_cycles_hold"}, row_cycles, busy_cnt);
`endif
  endtask

  initial begin
    clear_mon();
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_pulse", outsider_read_now, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_total", total_out, 32'd0);
    check("rst_addr_a", mem_a_addr, 10'd0);
    check("rst_dot_reset", dot_reset, 1'b1);
    check("rst_row_a", first_row_input[63:0], 64'd0);
`ifdef FEEDER_PERF_CNT_EN
    check("rst_row_cycles", row_cycles, 32'd0);
`endif
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Two packages, gap 2 -> pulses 5 apart
    clear_mon();
    start_row(32'd128, 10'd0, 10'd16);
    wait_pulses("t1_pulses", 2);
    check("t1_spacing", qget(pulse_cyc, 1) - qget(pulse_cyc, 0), 5);
    check("t1_a0", qget(a_addrs, 0), 0);
    check("t1_a1", qget(a_addrs, 1), 1);
    check("t1_b0", qget(b_addrs, 0), 16);
    check("t1_b1", qget(b_addrs, 1), 17);
    check("t1_dot_reset", dr_cnt, 2);
    check("t1_total", total_out, 32'd128);
    check("t1_busy", busy, 1'b1);
    check_pkgs("t1", 2, 10'd0, 10'd16);
    finish_row("t1", 1'b1, 32'd128);

    // npk = 0: only CLEAR, then done
    clear_mon();
    start_row(32'd40, 10'd3, 10'd4);
    repeat (6) tick();
    check("t2_dot_reset", dr_cnt, 2);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_after_clear", done_cyc - dr_last, 1);
    check("t2_rd_cnt", rd_cnt, 0);
    check("t2_pulses", pulse_cyc.size(), 0);
`ifdef FEEDER_PERF_CNT_EN
    check("t2_row_cycles", row_cycles, 32'd2);
`endif

    // Address wrap
    clear_mon();
    start_row(32'd192, 10'd1023, 10'd5);
    wait_pulses("t3_pulses", 3);
    check("t3_a0", qget(a_addrs, 0), 1023);
    check("t3_a1", qget(a_addrs, 1), 0);
    check("t3_a2", qget(a_addrs, 2), 1);
    check("t3_b2", qget(b_addrs, 2), 7);
    check_pkgs("t3", 3, 10'd1023, 10'd5);
    finish_row("t3", 1'b0, 32'd192);

    // dot_finish stuck high from the previous row: level must not finish the row
    clear_mon();
    fin_force = 1'b1;
    start_row(32'd64, 10'd2, 10'd3);
    wait_pulses("t4_pulses", 1);
    repeat (8) tick();
    check("t4_no_done_high", done_cnt, 0);
    check("t4_busy_drain", busy, 1'b1);
    fin_force = 1'b0;
    repeat (3) tick();
    check("t4_no_done_low", done_cnt, 0);
    finish_row("t4", 1'b0, 32'd64);

    // Start while busy ignored; reset mid-row aborts without done
    clear_mon();
    start_row(32'd128, 10'd4, 10'd8);
    tick();
    start_row(32'd999, 10'd100, 10'd200);
    wait_pulses("t5_pulses", 1);
    check("t5_total_kept", total_out, 32'd128);
    check("t5_a0", qget(a_addrs, 0), 4);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_pulse", outsider_read_now, 1'b0);
    check("t5_rst_total", total_out, 32'd0);
    check("t5_rst_dot_reset", dot_reset, 1'b1);
    check("t5_rst_row_a", first_row_input[63:0], 64'd0);
    check("t5_rst_addr_a", mem_a_addr, 10'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_idle", busy, 1'b0);

    clear_mon();
    start_row(32'd64, 10'd9, 10'd10);
    wait_pulses("t6_pulses", 1);
    check("t6_a0", qget(a_addrs, 0), 9);
    check("t6_dot_reset", dr_cnt, 2);
    check_pkgs("t6", 1, 10'd9, 10'd10);
    repeat (5) tick();
    finish_row("t6", 1'b0, 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
